// File: rtl/dtmf_pkg.sv
// -----------------------------------------------------------------------------
// dtmf_pkg
//   Shared DTMF frequency plan for the tone generator and the tone detector.
//   Holds the keypad frequency tables, the phase-accumulator tuning words
//   (8 kHz sample rate, 24-bit phase), the generator FSM state codes, the
//   sine table geometry and the quarter-wave sine helper used to build the ROM.
// -----------------------------------------------------------------------------
package dtmf_pkg;

    localparam int PHASE_W   = 24;   // phase accumulator width
    localparam int SIN_W     = 14;   // signed sine output width, range +/-8191
    localparam int LUT_DEPTH = 256;  // quarter-wave table entries

    // Keypad frequency plan, indexed by key[3:2] (row) and key[1:0] (col).
    // The detector's bins are tuned to these same frequencies.
    localparam int ROW_FREQ_HZ [4] = '{697, 770, 852, 941};
    localparam int COL_FREQ_HZ [4] = '{1209, 1336, 1477, 1633};

    // round(f * 2^24 / 8000) for each frequency above.
    localparam logic [PHASE_W-1:0] ROW_FTW [4] = '{
        24'd1461715, 24'd1614807, 24'd1786774, 24'd1973420
    };
    localparam logic [PHASE_W-1:0] COL_FTW [4] = '{
        24'd2535457, 24'd2801795, 24'd3097494, 24'd3424649
    };

    // Generator FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Quarter-wave table entry i = round(8191 * sin((i + 0.5) * pi / 512)).
    // Only evaluated at elaboration to fill a constant ROM.
    function automatic logic [SIN_W-2:0] quarter_sine(input int i);
        real x;
        x = 8191.0 * $sin((real'(i) + 0.5) * 3.14159265358979 / 512.0);
        return (SIN_W-1)'($rtoi(x + 0.5));
    endfunction

endpackage

// File: rtl/dtmf_sine_lut.sv
// -----------------------------------------------------------------------------
// dtmf_sine_lut
//   Registered full-wave sine lookup built from a 256-entry quarter-wave ROM.
//   phase[9:8] selects the quadrant, phase[7:0] indexes the ROM; quadrants 1
//   and 3 walk the table backwards, quadrants 2 and 3 negate the result.
//
//   clk    in   system clock
//   reset  in   synchronous active-high reset (clears the output register)
//   phase  in   top 10 bits of the phase accumulator
//   value  out  signed 14-bit sine, registered (1 cycle latency)
// -----------------------------------------------------------------------------
module dtmf_sine_lut
    import dtmf_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              phase,
    output logic signed [SIN_W-1:0] value
);

    // NOTE: the ROM is a constant, so it has no reset; only the output
    // register that holds state gets one.
    logic [SIN_W-2:0] rom [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
        assign rom[g] = quarter_sine(g);
    end

    logic [7:0]              idx;
    logic signed [SIN_W-1:0] mag;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        idx = phase[7:0];
        if (phase[8]) begin
            idx = ~phase[7:0];
        end
        mag = $signed({1'b0, rom[idx]});
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= phase[9] ? -mag : mag;
        end
    end

endmodule

// File: rtl/dtmf_tone_generator.sv
// -----------------------------------------------------------------------------
// dtmf_tone_generator
//   Synthesises one DTMF burst per accepted start: TONE_SAMPLES samples of the
//   row+col dual tone followed by GAP_SAMPLES zero samples, one sample per
//   CLK_DIV clocks, then a one-cycle done pulse.
//
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   start         in   burst request, sampled only while ready=1
//   key           in   keypad code, row=key[3:2], col=key[1:0]
//   ready         out  idle, start will be accepted
//   busy          out  burst in progress (~ready)
//   sample_valid  out  one-cycle strobe per output sample
//   sample        out  signed 16-bit sample, held between strobes
//   done          out  one-cycle pulse together with the final gap strobe
// -----------------------------------------------------------------------------
module dtmf_tone_generator
    import dtmf_pkg::*;
#(
    parameter int CLK_DIV      = 6250,  // clocks per sample tick, >= 3
    parameter int TONE_SAMPLES = 400,
    parameter int GAP_SAMPLES  = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  key,
    output logic        ready,
    output logic        busy,
    output logic        sample_valid,
    output logic [15:0] sample,
    output logic        done
);

    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAX_SAMPLES = (TONE_SAMPLES > GAP_SAMPLES) ? TONE_SAMPLES : GAP_SAMPLES;
    localparam int CNT_W       = $clog2(MAX_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);

    logic [1:0]              state;
    logic [PHASE_W-1:0]      row_ftw, col_ftw;
    logic [PHASE_W-1:0]      row_phase, col_phase;
    logic [DIV_W-1:0]        div_cnt;
    logic [CNT_W-1:0]        smp_cnt;
    logic                    tick;
    logic                    lut_valid, lut_gap, lut_last;
    logic signed [SIN_W-1:0] row_sin, col_sin;

    assign tick  = (state != ST_IDLE) && (div_cnt == DIV_LAST);
    assign ready = (state == ST_IDLE);
    assign busy  = ~ready;

    // The LUTs see the pre-increment phase on the tick cycle, so sample 0 of
    // every burst is taken at phase 0.
    dtmf_sine_lut u_row_lut (
        .clk   (clk),
        .reset (reset),
        .phase (row_phase[PHASE_W-1 -: 10]),
        .value (row_sin)
    );

    dtmf_sine_lut u_col_lut (
        .clk   (clk),
        .reset (reset),
        .phase (col_phase[PHASE_W-1 -: 10]),
        .value (col_sin)
    );

    // Burst sequencing: divider, sample counter and phase accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            row_ftw   <= '0;
            col_ftw   <= '0;
            row_phase <= '0;
            col_phase <= '0;
            div_cnt   <= '0;
            smp_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_ftw   <= ROW_FTW[key[3:2]];
                        col_ftw   <= COL_FTW[key[1:0]];
                        row_phase <= '0;
                        col_phase <= '0;
                        div_cnt   <= '0;
                        smp_cnt   <= '0;
                        state     <= ST_TONE;
                    end
                end
                ST_TONE: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        row_phase <= row_phase + row_ftw;
                        col_phase <= col_phase + col_ftw;
                        if (smp_cnt == TONE_LAST) begin
                            smp_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick && smp_cnt != GAP_LAST) begin
                        smp_cnt <= smp_cnt + 1'b1;
                    end
                    // Stay busy until the final gap sample has drained out of
                    // the pipeline, so ready rises the cycle after done.
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output pipeline: tick -> LUT register -> summed sample register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_valid    <= 1'b0;
            lut_gap      <= 1'b0;
            lut_last     <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
            done         <= 1'b0;
        end else begin
            lut_valid    <= tick;
            lut_gap      <= (state == ST_GAP);
            lut_last     <= tick && (state == ST_GAP) && (smp_cnt == GAP_LAST);
            sample_valid <= lut_valid;
            done         <= lut_last;
            if (lut_valid) begin
                // |row + col| <= 16382 fits 16 bits without saturation.
                sample <= lut_gap ? '0
                        : {{(16-SIN_W){row_sin[SIN_W-1]}}, row_sin}
                        + {{(16-SIN_W){col_sin[SIN_W-1]}}, col_sin};
            end
        end
    end

endmodule
